tx_iq_feeder: RTL and testbench

//  Host-side producer for the transmit IQ path: accepts the 16-bit host sample stream, pairs
//  it into 32-bit {I,Q} words and buffers them in a FIFO. Answers the transmitter's

---
 rtl/tx_iq_feeder.sv | 169 ++++++++++++++++
 tb/tb_tx_iq_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_iq_feeder.sv
// Transmit IQ feeder: pairs host half-samples into {I,Q} words, buffers them in a show-ahead
// FIFO and serves the transmitter pull interface. Optional ramp-in: define TX_IQ_FEEDER_RAMP_EN.
module tx_iq_feeder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LOW_WM     = 256,
  parameter int HIGH_WM    = 768
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [15:0]        wr_data,
  input  logic                      wr_en,
  input  logic                      wr_sync,
  input  logic                      ptt,
  input  logic                      tsiq_read_strobe,
  output logic        [31:0]        tsiq_data,
  output logic                      tsiq_valid,
  output logic        [DEPTH_LOG2:0] fill_level,
  output logic                      almost_full,
  output logic        [15:0]        underflow_cnt,
  output logic        [15:0]        overflow_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LOW_LVL  = (DEPTH_LOG2+1)'(LOW_WM);
  localparam logic [DEPTH_LOG2:0]   HIGH_LVL = (DEPTH_LOG2+1)'(HIGH_WM);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef TX_IQ_FEEDER_RAMP_EN
  function automatic logic [31:0] ramp_scale(input logic [31:0] w, input logic [6:0] k);
    logic signed [15:0] si, sq;
    logic signed [22:0] ks, pi, pq;
    si = w[31:16];
    sq = w[15:0];
    ks = signed'(23'(k));
    pi = (23'(si) * ks) >>> 6;
    pq = (23'(sq) * ks) >>> 6;
    return {pi[15:0], pq[15:0]};
  endfunction
`endif

  logic [1:0]            state, state_nxt;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   fill_nxt;
  logic                  phase_q, phase_nxt;
  logic signed [15:0]    i_hold_p0;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           pair_word, head_nxt, head_out, data_nxt;
  logic                  flush, arm, take_i, wr_pair, push, drop, pop, underrun;
  logic [15:0]           uf_nxt, ov_nxt;

  assign tsiq_valid = (state != S_IDLE);
  assign pair_word  = {i_hold_p0, wr_data};

  always_comb begin
    flush    = (state != S_IDLE) && !ptt;
    arm      = (state == S_IDLE) && ptt;
    take_i   = wr_en && (wr_sync || !phase_q);
    wr_pair  = wr_en && !wr_sync && phase_q;
    push     = wr_pair && (fill_level != FULL_LVL) && !flush;
    drop     = wr_pair && (fill_level == FULL_LVL) && !flush;
    pop      = (state == S_RUN) && ptt && tsiq_read_strobe && (fill_level != '0);
    underrun = (state == S_RUN) && ptt && tsiq_read_strobe && (fill_level == '0);

    state_nxt = state;
    if (!ptt) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_PRIME;
        S_PRIME: if (fill_level >= LOW_LVL) state_nxt = S_RUN;
        S_RUN:   state_nxt = S_RUN;
        default: state_nxt = S_IDLE;
      endcase
    end

    wr_ptr_nxt = push ? wr_ptr + PTR_ONE : wr_ptr;
    rd_ptr_nxt = pop  ? rd_ptr + PTR_ONE : rd_ptr;
    case ({push, pop})
      2'b10:   fill_nxt = fill_level + LVL_ONE;
      2'b01:   fill_nxt = fill_level - LVL_ONE;
      default: fill_nxt = fill_level;
    endcase

    phase_nxt = phase_q;
    if (wr_en)        phase_nxt = wr_sync ? 1'b1 : !phase_q;
    else if (wr_sync) phase_nxt = 1'b0;

    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      fill_nxt   = '0;
      phase_nxt  = 1'b0;
    end

    uf_nxt = arm ? 16'd0 : (underrun ? sat_inc16(underflow_cnt) : underflow_cnt);
    ov_nxt = arm ? 16'd0 : (drop ? sat_inc16(overflow_cnt) : overflow_cnt);

    // A word written into an empty (or just-emptied) FIFO becomes the head in the same edge.
    head_nxt = mem[rd_ptr_nxt];
    if (push && (wr_ptr == rd_ptr_nxt)) head_nxt = pair_word;
  end

`ifdef TX_IQ_FEEDER_RAMP_EN
  logic [6:0] ramp_k, ramp_k_nxt;

  always_comb begin
    ramp_k_nxt = ramp_k;
    if ((state == S_PRIME) && (state_nxt == S_RUN)) ramp_k_nxt = 7'd1;
    else if (underrun)                              ramp_k_nxt = 7'd1;
    else if (pop && (ramp_k != 7'd64))              ramp_k_nxt = ramp_k + 7'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ramp_k <= 7'd1;
    else        ramp_k <= ramp_k_nxt;
  end

  assign head_out = ramp_scale(head_nxt, ramp_k_nxt);
`else
  assign head_out = head_nxt;
`endif

  always_comb begin
    data_nxt = '0;
    if ((state_nxt == S_RUN) && (fill_nxt != '0)) data_nxt = head_out;
  end

  // p0: I half held until its Q partner arrives; storage written on pair completion
  always_ff @(posedge clk) begin
    if (take_i) i_hold_p0 <= wr_data;
    if (push)   mem[wr_ptr] <= pair_word;
  end

  // control and registered head presentation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_level    <= '0;
      phase_q       <= 1'b0;
      tsiq_data     <= '0;
      almost_full   <= 1'b0;
      underflow_cnt <= '0;
      overflow_cnt  <= '0;
    end else begin
      state         <= state_nxt;
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      fill_level    <= fill_nxt;
      phase_q       <= phase_nxt;
      tsiq_data     <= data_nxt;
      almost_full   <= (fill_nxt >= HIGH_LVL);
      underflow_cnt <= uf_nxt;
      overflow_cnt  <= ov_nxt;
    end
  end

endmodule

// File: tb/tb_tx_iq_feeder.sv
// Bench for tx_iq_feeder: vector table, directed corner sequences and a random run
// against a queue-based reference model.
module tb_tx_iq_feeder;
  localparam int DL2    = 10;
  localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2;
`ifdef TX_IQ_FEEDER_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0;
  logic signed [15:0] wr_data = '0;
  logic wr_en = 1'b0, wr_sync = 1'b0, ptt = 1'b0, strobe = 1'b0;
  logic [31:0] tsiq_data;
  logic tsiq_valid, almost_full;
  logic [DL2:0] fill_level;
  logic [15:0] uf_cnt, ov_cnt;

  int n_pass = 0, n_chk = 0;

  int          m_st, m_uf, m_ov, m_k;
  logic [31:0] m_q[$];
  bit          m_phase;
  logic [15:0] m_hold;

  typedef struct {
    logic ptt, en, sy, st;
    logic [15:0] d;
    logic [DL2:0] fill;
    logic valid;
    logic [31:0] data;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  tx_iq_feeder #(.DEPTH_LOG2(DL2), .LOW_WM(256), .HIGH_WM(768)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .wr_sync(wr_sync),
    .ptt(ptt), .tsiq_read_strobe(strobe), .tsiq_data(tsiq_data), .tsiq_valid(tsiq_valid),
    .fill_level(fill_level), .almost_full(almost_full), .underflow_cnt(uf_cnt),
    .overflow_cnt(ov_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Amplitude ramp as plain integer arithmetic; factor 64 is unity.
  function automatic logic [31:0] scaled(input logic [31:0] w, input int k);
    logic signed [31:0] i, q;
    int f;
    f = RAMP ? k : 64;
    i = {{16{w[31]}}, w[31:16]};
    q = {{16{w[15]}}, w[15:0]};
    i = (i * f) >>> 6;
    q = (q * f) >>> 6;
    return {i[15:0], q[15:0]};
  endfunction

  task automatic write_pair(input logic [15:0] i, input logic [15:0] q);
    wr_en = 1'b1; wr_data = i; step();
    wr_data = q; step();
    wr_en = 1'b0;
  endtask

  task automatic do_strobe(input string name, input logic [31:0] exp);
    strobe = 1'b1;
    check(name, tsiq_data, exp);
    step();
    strobe = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b0; ptt = 1'b0; wr_en = 1'b0; wr_sync = 1'b0; strobe = 1'b0;
    step();
    reset = 1'b1;
    step();
    m_st = M_IDLE; m_q.delete(); m_phase = 1'b0; m_uf = 0; m_ov = 0; m_k = 1;
  endtask

  task automatic model_step(input logic p, input logic en, input logic sy, input logic st,
                            input logic [15:0] d);
    int sz;
    sz = m_q.size();
    if (!p && m_st != M_IDLE) begin
      m_st = M_IDLE; m_q.delete(); m_phase = 1'b0;
    end else begin
      if (m_st == M_RUN && st) begin
        if (sz > 0) begin
          void'(m_q.pop_front());
          m_k = (m_k < 64) ? m_k + 1 : 64;
        end else begin
          m_uf = (m_uf < 65535) ? m_uf + 1 : m_uf;
          m_k = 1;
        end
      end
      if (en) begin
        if (sy || !m_phase) begin
          m_hold = d; m_phase = 1'b1;
        end else begin
          if (sz >= 1024) m_ov = (m_ov < 65535) ? m_ov + 1 : m_ov;
          else m_q.push_back({m_hold, d});
          m_phase = 1'b0;
        end
      end else if (sy) begin
        m_phase = 1'b0;
      end
      if (m_st == M_IDLE && p) begin
        m_st = M_PRIME; m_uf = 0; m_ov = 0;
      end else if (m_st == M_PRIME && sz >= 256) begin
        m_st = M_RUN; m_k = 1;
      end
    end
  endtask

  task automatic model_check(input int c);
    logic [31:0] exp_d;
    exp_d = (m_st == M_RUN && m_q.size() > 0) ? scaled(m_q[0], m_k) : 32'd0;
    check($sformatf("rnd%0d_data", c), tsiq_data, exp_d);
    check($sformatf("rnd%0d_valid", c), 32'(tsiq_valid), 32'(m_st != M_IDLE));
    check($sformatf("rnd%0d_fill", c), 32'(fill_level), 32'(m_q.size()));
    check($sformatf("rnd%0d_af", c), 32'(almost_full), 32'(m_q.size() >= 768));
    check($sformatf("rnd%0d_uf", c), 32'(uf_cnt), 32'(m_uf));
    check($sformatf("rnd%0d_ov", c), 32'(ov_cnt), 32'(m_ov));
  endtask

  initial begin
    logic [31:0] lit[3];
    logic p, en, sy, st;
    logic [15:0] d;
    int gap, pct;

    lit[0] = 32'h0100_0100; lit[1] = 32'h0200_0200; lit[2] = 32'h0300_0300;
    //           ptt   en    sy    st    d          fill  valid data
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd3,     11'd0, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd4,     11'd1, 1'b0, 32'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     11'd1, 1'b1, 32'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd0,     11'd1, 1'b1, 32'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     11'd0, 1'b0, 32'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd7,     11'd0, 1'b0, 32'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0,     11'd0, 1'b0, 32'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd7,     11'd0, 1'b0, 32'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd9,     11'd1, 1'b0, 32'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd5,     11'd1, 1'b0, 32'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd6,     11'd1, 1'b0, 32'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF,  11'd2, 1'b0, 32'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     11'd2, 1'b0, 32'd0};

    // reset values
    #1;
    check("rst_data", tsiq_data, 32'd0);
    check("rst_valid", 32'(tsiq_valid), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_uf", 32'(uf_cnt), 32'd0);
    check("rst_ov", 32'(ov_cnt), 32'd0);
    do_reset();

    // vector table: pairing, wr_sync, PRIME behaviour, flush on ptt drop
    for (int i = 0; i < 13; i++) begin
      ptt = tbl[i].ptt; wr_en = tbl[i].en; wr_sync = tbl[i].sy; strobe = tbl[i].st;
      wr_data = tbl[i].d;
      step();
      check($sformatf("vec%0d_fill", i), 32'(fill_level), 32'(tbl[i].fill));
      check($sformatf("vec%0d_valid", i), 32'(tsiq_valid), 32'(tbl[i].valid));
      check($sformatf("vec%0d_data", i), tsiq_data, tbl[i].data);
    end
    ptt = 1'b0; wr_en = 1'b0; wr_sync = 1'b0; strobe = 1'b0;
    for (int n = 0; n < 254; n++) write_pair(16'(n), 16'(n));
    ptt = 1'b1; step(); step();
    check("sync_run_valid", 32'(tsiq_valid), 32'd1);
    do_strobe("sync_word0", scaled(32'h0007_0009, 1));
    do_strobe("sync_word1", scaled(32'h0006_FFFF, 2));
    check("sync_uf", 32'(uf_cnt), 32'd0);

    // priming, full drain, underflow, recovery, mid-RUN reset
    do_reset();
    ptt = 1'b1; step();
    for (int n = 0; n < 256; n++) write_pair(16'h1000 + 16'(n), 16'(n));
    step();
    check("prime_fill", 32'(fill_level), 32'd256);
    check("prime_valid", 32'(tsiq_valid), 32'd1);
    for (int n = 0; n < 256; n++)
      do_strobe($sformatf("drain%0d", n),
                scaled({16'h1000 + 16'(n), 16'(n)}, (n + 1 < 64) ? n + 1 : 64));
    check("drain_fill", 32'(fill_level), 32'd0);
    for (int n = 0; n < 5; n++) do_strobe($sformatf("uflow%0d", n), 32'd0);
    check("uflow_cnt", 32'(uf_cnt), 32'd5);
    check("uflow_valid", 32'(tsiq_valid), 32'd1);
    write_pair(16'h1234, 16'h5678);
    do_strobe("recover", scaled(32'h1234_5678, 1));
    check("recover_uf", 32'(uf_cnt), 32'd5);
    write_pair(16'h1111, 16'h2222);
    write_pair(16'h3333, 16'h4444);
    reset = 1'b0;
    #1;
    check("midrst_data", tsiq_data, 32'd0);
    check("midrst_valid", 32'(tsiq_valid), 32'd0);
    check("midrst_fill", 32'(fill_level), 32'd0);
    check("midrst_uf", 32'(uf_cnt), 32'd0);
    step();
    reset = 1'b1;
    step();
    check("postrst_fill", 32'(fill_level), 32'd0);

    // overflow while prefilling in IDLE
    do_reset();
    for (int n = 0; n < 1027; n++) begin
      write_pair(16'(n), ~16'(n));
      if (n == 766) check("af_767", 32'(almost_full), 32'd0);
      if (n == 767) check("af_768", 32'(almost_full), 32'd1);
    end
    check("ovf_fill", 32'(fill_level), 32'd1024);
    check("ovf_cnt", 32'(ov_cnt), 32'd3);
    check("ovf_af", 32'(almost_full), 32'd1);
    ptt = 1'b1; step();
    check("arm_ov_clear", 32'(ov_cnt), 32'd0);
    step();
    check("ovf_head", tsiq_data, scaled(32'h0000_FFFF, 1));

    // ramp-in start and ptt release
    do_reset();
    ptt = 1'b1; step();
    for (int n = 0; n < 256; n++) write_pair(16'h4000, 16'h4000);
    step();
    for (int j = 0; j < 3; j++)
      do_strobe($sformatf("ramp%0d", j), RAMP ? lit[j] : 32'h4000_4000);
    ptt = 1'b0; step();
    check("ptt_off_valid", 32'(tsiq_valid), 32'd0);
    check("ptt_off_fill", 32'(fill_level), 32'd0);
    check("ptt_off_data", tsiq_data, 32'd0);

    // randomized run against the reference model
    do_reset();
    gap = 2;
    for (int c = 0; c < 4000; c++) begin
      p   = !(c < 40 || (c >= 2600 && c < 2610));
      pct = (c < 1200) ? 70 : (c < 2200) ? 5 : (c < 2600) ? 90 : 70;
      en  = ($urandom_range(99) < pct);
      sy  = ($urandom_range(99) < 3);
      st  = (gap >= 2) && ($urandom_range(1) == 1);
      gap = st ? 0 : gap + 1;
      d   = 16'($urandom);
      ptt = p; wr_en = en; wr_sync = sy; strobe = st; wr_data = d;
      model_step(p, en, sy, st, d);
      step();
      model_check(c);
    end
    ptt = 1'b0; wr_en = 1'b0; wr_sync = 1'b0; strobe = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
